// File: rtl/cp0_ctrl.sv
// cp0_ctrl: Coprocessor-0 responder for the 5-stage MIPS pipeline.
//   clk, rst                 : clock, synchronous active-high reset
//   mem_cp0op/cs/sel/busB/pc : CP0 op and operands of the instruction in MEM
//   ext_int                  : level external interrupt lines
//   ex_cs, ex_sel            : mfc0 read address from EX
//   ex_cp0_dout              : mfc0 read data (combinational, forwards MEM mtc0)
//   cp0bubble                : flush code 0 none, 1 flush IF/ID/EX, 2 cancel cp0op in EX/MEM
//   redirect_valid/pc        : PC redirect request and target
//   cp0_status/cause/epc     : architectural registers for debug
module cp0_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter bit          COUNT_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_cp0op,
    input  logic [4:0]  mem_cs,
    input  logic [2:0]  mem_sel,
    input  logic [31:0] mem_busB,
    input  logic [31:0] mem_pc,
    input  logic [5:0]  ext_int,
    input  logic [4:0]  ex_cs,
    input  logic [2:0]  ex_sel,
    output logic [31:0] ex_cp0_dout,
    output logic [1:0]  cp0bubble,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_epc
);
    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;
    localparam logic [2:0] OP_MTC0 = 3'b010;
    localparam logic [2:0] OP_SYSCALL = 3'b011;
    localparam logic [2:0] OP_ERET = 3'b100;

    state_t state_q, state_d;
    logic [31:0] count_q, count_d, compare_q, compare_d, epc_q, epc_d;
    logic        timer_pend_q, timer_pend_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [1:0]  bubble_q, bubble_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] status, cause, rd_data, target;
    logic        idle, wr, syscall, eret, irq, take_irq, event_hit, fwd;

    // Writable bits of each implemented register; zero for unimplemented ones.
    function automatic logic [31:0] wmask(input logic [4:0] cs, input logic [2:0] sel);
        return (sel != 3'd0) ? 32'h0 :
               (cs == 5'd9 || cs == 5'd11 || cs == 5'd14) ? 32'hFFFF_FFFF :
               (cs == 5'd12) ? 32'h0000_FF03 :
               (cs == 5'd13) ? 32'h0000_0300 : 32'h0;
    endfunction

    always_comb begin
        status = {16'h0, im_q, 6'h0, exl_q, ie_q};
        cause = {16'h0, ip_hw_q, ip_sw_q, 1'b0, exc_q, 2'b0};
        rd_data = (ex_sel != 3'd0) ? 32'h0 :
                  (ex_cs == 5'd9)  ? count_q :
                  (ex_cs == 5'd11) ? compare_q :
                  (ex_cs == 5'd12) ? status :
                  (ex_cs == 5'd13) ? cause :
                  (ex_cs == 5'd14) ? epc_q : 32'h0;
        fwd = mem_cp0op == OP_MTC0 && mem_cs == ex_cs && mem_sel == ex_sel;
        ex_cp0_dout = fwd ? (mem_busB & wmask(ex_cs, ex_sel)) : rd_data;
        idle = state_q == IDLE;
        // Flushed instructions in FLUSH/DRAIN neither write nor raise events.
        wr = idle && mem_cp0op == OP_MTC0 && mem_sel == 3'd0;
        syscall = idle && mem_cp0op == OP_SYSCALL;
        eret = idle && mem_cp0op == OP_ERET;
        irq = ie_q & ~exl_q & |(cause[15:8] & im_q);
        take_irq = idle && irq && mem_cp0op != OP_MTC0 && !syscall && !eret;
        event_hit = syscall || eret || take_irq;
        target = eret ? epc_q : EXC_VECTOR;
        count_d = (wr && mem_cs == 5'd9) ? mem_busB : count_q + {31'd0, COUNT_EN};
        compare_d = (wr && mem_cs == 5'd11) ? mem_busB : compare_q;
        timer_pend_d = (wr && mem_cs == 5'd11) ? 1'b0 : timer_pend_q | (count_q == compare_q);
        ip_hw_d = {timer_pend_d | ext_int[5], ext_int[4:0]};
        im_d = (wr && mem_cs == 5'd12) ? mem_busB[15:8] : im_q;
        ie_d = (wr && mem_cs == 5'd12) ? mem_busB[0] : ie_q;
        // Event side effects override a coincident mtc0 on EXL/ExcCode.
        exl_d = (syscall || take_irq) ? 1'b1 : eret ? 1'b0 :
                (wr && mem_cs == 5'd12) ? mem_busB[1] : exl_q;
        ip_sw_d = (wr && mem_cs == 5'd13) ? mem_busB[9:8] : ip_sw_q;
        exc_d = syscall ? 5'd8 : take_irq ? 5'd0 : exc_q;
        // An interrupt lets the MEM instruction commit, so resume after it.
        epc_d = syscall ? mem_pc : take_irq ? mem_pc + 32'd4 :
                (wr && mem_cs == 5'd14) ? mem_busB : epc_q;
        state_d = idle ? (event_hit ? FLUSH : IDLE) : (state_q == FLUSH) ? DRAIN : IDLE;
        bubble_d = (state_d == FLUSH) ? 2'd1 : (state_d == DRAIN) ? 2'd2 : 2'd0;
        redirect_valid_d = state_d == FLUSH;
        redirect_pc_d = event_hit ? target : redirect_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 32'h0;
            compare_q <= 32'hFFFF_FFFF;
            epc_q <= 32'h0;
            timer_pend_q <= 1'b0;
            im_q <= 8'h0;
            exl_q <= 1'b0;
            ie_q <= 1'b0;
            ip_hw_q <= 6'h0;
            ip_sw_q <= 2'h0;
            exc_q <= 5'h0;
            bubble_q <= 2'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            compare_q <= compare_d;
            epc_q <= epc_d;
            timer_pend_q <= timer_pend_d;
            im_q <= im_d;
            exl_q <= exl_d;
            ie_q <= ie_d;
            ip_hw_q <= ip_hw_d;
            ip_sw_q <= ip_sw_d;
            exc_q <= exc_d;
            bubble_q <= bubble_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign cp0bubble = bubble_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc = redirect_pc_q;
    assign cp0_status = status;
    assign cp0_cause = cause;
    assign cp0_epc = epc_q;
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed and randomized checks of cp0_ctrl against a behavioural model.
module tb_cp0_ctrl;
    localparam logic [31:0] EXC = 32'h0000_0040;

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  mem_cp0op = 3'd0, mem_sel = 3'd0, ex_sel = 3'd0;
    logic [4:0]  mem_cs = 5'd0, ex_cs = 5'd0;
    logic [31:0] mem_busB = 32'h0, mem_pc = 32'h0;
    logic [5:0]  ext_int = 6'h0;
    logic [31:0] ex_cp0_dout, redirect_pc, cp0_status, cp0_cause, cp0_epc;
    logic [1:0]  cp0bubble;
    logic        redirect_valid;

    int checks = 0, failures = 0;

    // Architectural model: whole 32-bit register images plus a flush phase counter.
    logic [31:0] m_count = 0, m_compare = 32'hFFFF_FFFF, m_status = 0, m_cause = 0, m_epc = 0, m_rpc = 0;
    bit          m_tpend = 0, m_rv = 0;
    int          m_phase = 0;
    logic [1:0]  m_bub = 0;

    cp0_ctrl #(.EXC_VECTOR(EXC), .COUNT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_cp0op(mem_cp0op), .mem_cs(mem_cs), .mem_sel(mem_sel),
        .mem_busB(mem_busB), .mem_pc(mem_pc), .ext_int(ext_int), .ex_cs(ex_cs), .ex_sel(ex_sel),
        .ex_cp0_dout(ex_cp0_dout), .cp0bubble(cp0bubble), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] cs, input logic [2:0] sel);
        if (sel != 0) return 0;
        case (cs)
            9: return m_count;
            11: return m_compare;
            12: return m_status;
            13: return m_cause;
            14: return m_epc;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_mask(input logic [4:0] cs, input logic [2:0] sel);
        if (sel != 0) return 0;
        case (cs)
            9, 11, 14: return 32'hFFFF_FFFF;
            12: return 32'h0000_FF03;
            13: return 32'h0000_0300;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_dout();
        if (mem_cp0op == 3'd2 && mem_cs == ex_cs && mem_sel == ex_sel) return mem_busB & m_mask(ex_cs, ex_sel);
        return m_read(ex_cs, ex_sel);
    endfunction

    task automatic model_step();
        logic [31:0] st, ca, ep, cnt, cmp;
        bit idle, wr, sc, er, ti, pend;
        if (rst) begin
            m_count = 0; m_compare = 32'hFFFF_FFFF; m_status = 0; m_cause = 0; m_epc = 0;
            m_rpc = 0; m_tpend = 0; m_rv = 0; m_phase = 0; m_bub = 0;
            return;
        end
        st = m_status; ca = m_cause; ep = m_epc; cmp = m_compare;
        idle = m_phase == 0;
        wr = idle && mem_cp0op == 3'd2 && mem_sel == 0;
        sc = idle && mem_cp0op == 3'd3;
        er = idle && mem_cp0op == 3'd4;
        ti = idle && !(mem_cp0op inside {3'd2, 3'd3, 3'd4}) && m_status[0] && !m_status[1]
             && ((m_cause[15:8] & m_status[15:8]) != 0);
        cnt = m_count + 1;
        pend = m_tpend || (m_count == m_compare);
        if (wr) begin
            case (mem_cs)
                9: cnt = mem_busB;
                11: begin cmp = mem_busB; pend = 0; end
                12: st = mem_busB & 32'h0000_FF03;
                13: ca = (ca & ~32'h0000_0300) | (mem_busB & 32'h0000_0300);
                14: ep = mem_busB;
                default: ;
            endcase
        end
        ca[15:10] = {pend | ext_int[5], ext_int[4:0]};
        if (sc) begin ep = mem_pc; ca[6:2] = 5'd8; st[1] = 1; end
        else if (er) st[1] = 0;
        else if (ti) begin ep = mem_pc + 4; ca[6:2] = 5'd0; st[1] = 1; end
        if (idle && (sc || er || ti)) begin
            m_phase = 1; m_rv = 1; m_bub = 1; m_rpc = er ? m_epc : EXC;
        end else if (m_phase == 1) begin
            m_phase = 2; m_rv = 0; m_bub = 2;
        end else begin
            m_phase = 0; m_rv = 0; m_bub = 0;
        end
        m_count = cnt; m_compare = cmp; m_status = st; m_cause = ca; m_epc = ep; m_tpend = pend;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [4:0] cs, input logic [31:0] d);
        mem_cp0op = op; mem_cs = cs; mem_sel = 3'd0; mem_busB = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_op(3'd0, 5'd0, 32'h0);
        ex_cs = 5'd9;
        #1;
        checks++;
        if ({cp0bubble, redirect_valid, redirect_pc, cp0_status, cp0_cause, cp0_epc} !== 131'd0) begin
            failures++;
            $display("FAIL reset_outputs: bub=%0d rv=%0b rpc=%h st=%h ca=%h epc=%h, need all 0",
                     cp0bubble, redirect_valid, redirect_pc, cp0_status, cp0_cause, cp0_epc);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (ex_cp0_dout !== 32'(k)) begin
                failures++;
                $display("FAIL reset_count: got %h need %h", ex_cp0_dout, 32'(k));
            end
        end
        ex_cs = 5'd11;
        #1;
        checks++;
        if (ex_cp0_dout !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_compare: got %h need ffffffff", ex_cp0_dout);
        end
    endtask

    task automatic test_mtc0_fwd();
        set_op(3'd2, 5'd14, 32'h1234_5678);
        ex_cs = 5'd14;
        #1;
        checks++;
        if (ex_cp0_dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL fwd_dout: got %h need 12345678", ex_cp0_dout);
        end
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        checks++;
        if (cp0_epc !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mtc0_epc: got %h need 12345678", cp0_epc);
        end
    endtask

    task automatic test_syscall();
        set_op(3'd3, 5'd0, 32'h0);
        mem_pc = 32'h0000_0100;
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        checks++;
        if ({redirect_valid, redirect_pc, cp0bubble} !== {1'b1, EXC, 2'd1}) begin
            failures++;
            $display("FAIL syscall_flush: rv=%0b rpc=%h bub=%0d need 1 %h 1", redirect_valid, redirect_pc, cp0bubble, EXC);
        end
        checks++;
        if ({cp0_epc, cp0_cause[6:2], cp0_status[1]} !== {32'h0000_0100, 5'd8, 1'b1}) begin
            failures++;
            $display("FAIL syscall_regs: epc=%h exc=%0d exl=%0b need 100 8 1", cp0_epc, cp0_cause[6:2], cp0_status[1]);
        end
        tick();
        checks++;
        if ({redirect_valid, cp0bubble} !== {1'b0, 2'd2}) begin
            failures++;
            $display("FAIL syscall_drain: rv=%0b bub=%0d need 0 2", redirect_valid, cp0bubble);
        end
        tick();
        checks++;
        if (cp0bubble !== 2'd0) begin
            failures++;
            $display("FAIL syscall_idle: bub=%0d need 0", cp0bubble);
        end
    endtask

    task automatic test_irq();
        set_op(3'd2, 5'd12, 32'h0000_8001);
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        ext_int = 6'b100000;
        mem_pc = 32'h0000_0200;
        tick();
        checks++;
        if (cp0_cause[15] !== 1'b1 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL irq_pending: ip7=%0b rv=%0b need 1 0", cp0_cause[15], redirect_valid);
        end
        tick();
        checks++;
        if ({redirect_valid, redirect_pc, cp0bubble} !== {1'b1, EXC, 2'd1}) begin
            failures++;
            $display("FAIL irq_flush: rv=%0b rpc=%h bub=%0d need 1 %h 1", redirect_valid, redirect_pc, cp0bubble, EXC);
        end
        checks++;
        if ({cp0_epc, cp0_cause[6:2], cp0_status[1]} !== {32'h0000_0204, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL irq_regs: epc=%h exc=%0d exl=%0b need 204 0 1", cp0_epc, cp0_cause[6:2], cp0_status[1]);
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({redirect_valid, cp0bubble} !== 3'd0) begin
                failures++;
                $display("FAIL irq_no_retrigger: rv=%0b bub=%0d need 0 0", redirect_valid, cp0bubble);
            end
        end
    endtask

    task automatic test_eret();
        ext_int = 6'h0;
        set_op(3'd2, 5'd14, 32'h0000_0300);
        tick();
        set_op(3'd4, 5'd0, 32'h0);
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        checks++;
        if ({redirect_valid, redirect_pc, cp0bubble, cp0_status[1]} !== {1'b1, 32'h0000_0300, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL eret_flush: rv=%0b rpc=%h bub=%0d exl=%0b need 1 300 1 0",
                     redirect_valid, redirect_pc, cp0bubble, cp0_status[1]);
        end
        tick();
        checks++;
        if (cp0bubble !== 2'd2) begin
            failures++;
            $display("FAIL eret_drain: bub=%0d need 2", cp0bubble);
        end
        tick();
        checks++;
        if (cp0bubble !== 2'd0) begin
            failures++;
            $display("FAIL eret_idle: bub=%0d need 0", cp0bubble);
        end
    endtask

    task automatic test_timer();
        set_op(3'd2, 5'd12, 32'h0);
        tick();
        set_op(3'd2, 5'd9, 32'h0);
        tick();
        set_op(3'd2, 5'd11, 32'h5);
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (cp0_cause[15] !== (k == 5)) begin
                failures++;
                $display("FAIL timer_rise cycle %0d: ip7=%0b need %0b", k, cp0_cause[15], k == 5);
            end
        end
        set_op(3'd2, 5'd11, 32'h0000_1000);
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        checks++;
        if (cp0_cause[15] !== 1'b0) begin
            failures++;
            $display("FAIL timer_clear: ip7=%0b need 0", cp0_cause[15]);
        end
    endtask

    task automatic test_drain_drop();
        set_op(3'd3, 5'd0, 32'h0);
        mem_pc = 32'h0000_0500;
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        tick();
        set_op(3'd2, 5'd14, 32'hDEAD_BEEF);
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        checks++;
        if ({cp0_epc, cp0bubble} !== {32'h0000_0500, 2'd0}) begin
            failures++;
            $display("FAIL drain_drop: epc=%h bub=%0d need 500 0", cp0_epc, cp0bubble);
        end
    endtask

    task automatic test_reset_in_flush();
        set_op(3'd3, 5'd0, 32'h0);
        mem_pc = 32'h0000_0600;
        tick();
        set_op(3'd0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cp0bubble, redirect_valid, redirect_pc, cp0_status, cp0_cause, cp0_epc} !== 131'd0) begin
            failures++;
            $display("FAIL reset_in_flush: bub=%0d rv=%0b rpc=%h st=%h ca=%h epc=%h, need all 0",
                     cp0bubble, redirect_valid, redirect_pc, cp0_status, cp0_cause, cp0_epc);
        end
    endtask

    task automatic test_random();
        logic [4:0] cs_tab [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        int r;
        logic [31:0] exp;
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 79) == 0;
            r = $urandom_range(0, 15);
            mem_cp0op = (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : (r < 12) ? 3'd2 : (r == 12) ? 3'd3 :
                        (r == 13) ? 3'd4 : 3'($urandom_range(5, 7));
            mem_cs = ($urandom_range(0, 4) != 0) ? cs_tab[$urandom_range(0, 4)] : 5'($urandom);
            mem_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            mem_busB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            mem_pc = $urandom;
            if ($urandom_range(0, 9) == 0) ext_int = 6'($urandom);
            ex_cs = ($urandom_range(0, 2) == 0) ? mem_cs : cs_tab[$urandom_range(0, 4)];
            ex_sel = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (ex_cs == mem_cs ? mem_sel : 3'd0);
            #1;
            exp = m_dout();
            checks++;
            if (ex_cp0_dout !== exp) begin
                failures++;
                $display("FAIL rand_dout %0d: got %h need %h", i, ex_cp0_dout, exp);
            end
            tick();
            checks++;
            if ({cp0bubble, redirect_valid, redirect_pc, cp0_status, cp0_cause, cp0_epc} !==
                {m_bub, m_rv, m_rpc, m_status, m_cause, m_epc}) begin
                failures++;
                $display("FAIL rand_state %0d: bub=%0d/%0d rv=%0b/%0b rpc=%h/%h st=%h/%h ca=%h/%h epc=%h/%h",
                         i, cp0bubble, m_bub, redirect_valid, m_rv, redirect_pc, m_rpc,
                         cp0_status, m_status, cp0_cause, m_cause, cp0_epc, m_epc);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mtc0_fwd();
        test_syscall();
        test_irq();
        test_eret();
        test_timer();
        test_drain_drop();
        test_reset_in_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 responder for the 5-stage MIPS pipeline.
- Consumes the CP0 fields carried out of the EX/MEM register: mem_cp0op, mem_cs, mem_sel, mem_busB and mem_pc.
- Services the CP0 register file for mfc0 reads from EX and mtc0 writes from MEM.
- Raises syscall, interrupt and eret events, and drives the cp0bubble flush code and the PC redirect back to the pipeline.

Parameters:
EXC_VECTOR  32'h0000_0040  exception/interrupt entry PC
COUNT_EN    1              1 = Count increments every cycle

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous reset, active-high
mem_cp0op  in  3  CP0 op in MEM: 000 nop, 001 mfc0, 010 mtc0, 011 syscall, 100 eret, others treated as nop
mem_cs  in  5  CP0 register number for the MEM op
mem_sel  in  3  CP0 select for the MEM op
mem_busB  in  32  mtc0 write data
mem_pc  in  32  PC of the instruction in MEM
ext_int  in  6  external interrupt lines, level, active-high
ex_cs  in  5  mfc0 read register number from EX
ex_sel  in  3  mfc0 read select from EX
ex_cp0_dout  out  32  mfc0 read data, combinational
cp0bubble  out  2  flush code: 0 none, 1 flush IF/ID/EX, 2 cancel cp0op in EX/MEM
redirect_valid  out  1  PC must be loaded with redirect_pc this cycle
redirect_pc  out  32  redirect target
cp0_status  out  32  Status register, for debug
cp0_cause  out  32  Cause register, for debug
cp0_epc  out  32  EPC register, for debug

Behaviour:
- Reset is synchronous: rst high at a posedge sets the following.
  - Status = 0, Cause = 0, EPC = 0, Count = 0, Compare = 32'hFFFF_FFFF.
  - State = IDLE; cp0bubble = 0, redirect_valid = 0, redirect_pc = 0.
  - Reset in any state aborts the sequence.
- Registers are implemented only for sel=0; all others read 0 and ignore writes.
  - Count (9): increments every cycle when COUNT_EN. An mtc0 write overrides the increment.
  - Compare (11): any write clears the timer pending flag. When Count == Compare, the timer pending flag is set.
  - Status (12): writable bits [15:8] IM, [1] EXL, [0] IE; all other bits read 0.
  - Cause (13):
    - [15] = timer_pend | ext_int[5], and [14:10] = ext_int[4:0], both registered every cycle.
    - [9:8] software IP, writable.
    - [6:2] ExcCode.
    - All other bits read 0.
  - EPC (14): full 32-bit read/write.
- mtc0 (op 010): the write takes effect at the posedge where it sits in MEM.
- mfc0 read path:
  - ex_cp0_dout is decoded combinationally from ex_cs/ex_sel.
  - If an mtc0 in MEM targets the same cs/sel, ex_cp0_dout returns the masked mem_busB (forwarding).
- Interrupt request: irq = IE & ~EXL & |(Cause[15:8] & IM).
- Events are sampled in IDLE only, with priority syscall > eret > irq.
  - syscall: EPC <= mem_pc; ExcCode <= 8; EXL <= 1; target = EXC_VECTOR.
  - eret: EXL <= 0; target = current EPC.
  - irq, taken only when mem_cp0op is nop or mfc0: the MEM instruction commits. EPC <= mem_pc + 4; ExcCode <= 0; EXL <= 1; target = EXC_VECTOR.
- State machine:
  - IDLE -> FLUSH on an event.
  - FLUSH (1 cycle): redirect_valid = 1, redirect_pc = target, cp0bubble = 1. Then go to DRAIN.
  - DRAIN (1 cycle): cp0bubble = 2, redirect_valid = 0. Then go to IDLE.
  - cp0bubble = 0 in IDLE.
  - All outputs are registered, so an event at posedge N gives FLUSH during cycle N+1 and DRAIN during N+2.
- In FLUSH/DRAIN, mem_cp0op events are ignored: those instructions are being flushed.
  - mtc0 writes in those states are also dropped.
  - Count still increments and Cause[15:10] still samples.
- If an mtc0 to Status or Cause coincides with an event at the same posedge, event side effects win on EXL and ExcCode. The remaining bits take the mtc0 data.
- Count wraps from 32'hFFFF_FFFF to 0.
- Arithmetic is 32-bit modulo; mem_pc + 4 wraps.

Test Plan:
- rst held 2 cycles, then released with ops nop -> all outputs 0, Count reads 1, 2, 3 via ex_cs=9, and Compare reads FFFF_FFFF.
- mtc0 cs=14 data 32'h1234_5678, with ex_cs=14 in the same cycle -> ex_cp0_dout = 1234_5678 combinationally, and EPC = 1234_5678 after the edge.
- syscall at mem_pc = 32'h0000_0100 -> next cycle redirect_valid=1, redirect_pc=0000_0040, cp0bubble=1.
  - Following cycle cp0bubble=2, then 0.
  - EPC=0000_0100, ExcCode=8, EXL=1.
- Status=32'h0000_8001 (IM7, IE), then ext_int[5]=1 with mem_pc=0000_0200 and op nop -> EPC=0000_0204, ExcCode=0, EXL=1, redirect to 0000_0040.
  - ext_int held with EXL=1 -> no second event.
- eret with EPC=0000_0300 -> redirect_pc=0000_0300, EXL cleared, bubble sequence 1, 2, 0.
- Write Compare=5 and Count=0 -> after 5 cycles Cause[15]=1. Then write Compare -> Cause[15]=0 on the next cycle.
  - An mtc0 issued during DRAIN is dropped.
  - rst asserted during FLUSH -> next cycle all outputs at reset values.
